// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizes rxd, frames start/data/stop on enable
// ticks, and holds the last good byte with rda/frame_err/overrun status.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 rxd,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   logic                 rxd_meta_q;
   logic                 rxd_s_q;
   state_e               state_q,   state_d;
   logic [TW-1:0]        tick_q,    tick_d;
   logic [BW-1:0]        bit_q,     bit_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 armed_q,   armed_d;
   logic                 rda_q,     rda_d;
   logic                 fe_q,      fe_d;
   logic                 ov_q,      ov_d;
   logic                 busy_q,    busy_d;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   // Next-state and status logic; acks apply every cycle, framing only on enable.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      armed_d   = armed_q;
      rx_data_d = rx_data_q;
      rda_d     = rd_ack ? 1'b0 : rda_q;
      fe_d      = rd_ack ? 1'b0 : fe_q;
      ov_d      = rd_ack ? 1'b0 : ov_q;

      if (enable) begin
         case (state_q)
            IDLE: begin
               // Armed only after a high tick, so a held-low line cannot retrigger.
               if (rxd_s_q) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = START;
                  tick_d  = '0;
                  armed_d = 1'b0;
               end else begin
                  armed_d = armed_q;
               end
            end
            START: begin
               if (tick_q == TICK_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rxd_s_q ? IDLE : DATA;
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) begin
                     bit_d   = '0;
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + BIT_ONE;
                  end
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = IDLE;
                  if (rxd_s_q) begin
                     rx_data_d = shift_q;
                     rda_d     = 1'b1;
                     fe_d      = 1'b0;
                     ov_d      = (rda_q && !rd_ack) ? 1'b1 : ov_d;
                  end else begin
                     fe_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + TICK_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               tick_d  = '0;
               bit_d   = '0;
               armed_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State, counters, data path and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         armed_q   <= 1'b0;
         rda_q     <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         armed_q   <= armed_d;
         rda_q     <= rda_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
         busy_q    <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rda       = rda_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; one enable tick every three clocks.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       rxd = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rda;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .rxd       (rxd),
      .rd_ack    (rd_ack),
      .rx_data   (rx_data),
      .rda       (rda),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // rxd is held for the whole tick; the gap clocks cover the synchronizer delay.
   task automatic tick(input logic ack);
      @(negedge clk); enable = 1'b0;
      @(negedge clk); enable = 1'b1; rd_ack = ack;
      @(negedge clk); enable = 1'b0; rd_ack = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int n);
      rxd = b;
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic idle(input int n);
      send_bit(1'b1, n);
   endtask

   // Start + data; the stop sample lands on the 9th tick of the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack);
      send_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) send_bit(d[i], 16);
      send_bit(stop, 8);
      tick(ack);
   endtask

   task automatic ack_pulse();
      @(negedge clk); rd_ack = 1'b1;
      @(negedge clk); rd_ack = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h0);
      chk("rst_rda", {31'd0, rda}, 32'h0);
      chk("rst_fe", {31'd0, frame_err}, 32'h0);
      chk("rst_ov", {31'd0, overrun}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      rst = 1'b0;

      // Good frame 0xA5
      idle(16);
      send_bit(1'b0, 16);
      chk("a5_busy_mid", {31'd0, busy}, 32'h1);
      for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i), 16);
      send_bit(1'b1, 8);
      chk("a5_rda_before", {31'd0, rda}, 32'h0);
      tick(1'b0);
      chk("a5_data", {24'd0, rx_data}, 32'hA5);
      chk("a5_rda", {31'd0, rda}, 32'h1);
      chk("a5_fe", {31'd0, frame_err}, 32'h0);
      chk("a5_busy", {31'd0, busy}, 32'h0);
      idle(7);
      ack_pulse();
      chk("a5_ack_rda", {31'd0, rda}, 32'h0);

      // False start: 4 low ticks
      idle(4);
      send_bit(1'b0, 4);
      chk("fs_busy_start", {31'd0, busy}, 32'h1);
      send_bit(1'b1, 4);
      chk("fs_busy_tick6", {31'd0, busy}, 32'h1);
      send_bit(1'b1, 1);
      chk("fs_busy_abort", {31'd0, busy}, 32'h0);
      chk("fs_rda", {31'd0, rda}, 32'h0);
      chk("fs_fe", {31'd0, frame_err}, 32'h0);
      chk("fs_data", {24'd0, rx_data}, 32'hA5);

      // Framing error 0x3C, then a stuck-low line
      idle(16);
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("fe_set", {31'd0, frame_err}, 32'h1);
      chk("fe_rda", {31'd0, rda}, 32'h0);
      chk("fe_data", {24'd0, rx_data}, 32'hA5);
      send_bit(1'b0, 40);
      chk("fe_stuck_busy", {31'd0, busy}, 32'h0);
      idle(16);
      ack_pulse();
      chk("fe_ack", {31'd0, frame_err}, 32'h0);

      // Overrun: 0x11 then 0x22 without ack
      idle(4);
      send_frame(8'h11, 1'b1, 1'b0);
      chk("ov1_data", {24'd0, rx_data}, 32'h11);
      chk("ov1_ov", {31'd0, overrun}, 32'h0);
      idle(7);
      send_frame(8'h22, 1'b1, 1'b0);
      chk("ov2_data", {24'd0, rx_data}, 32'h22);
      chk("ov2_rda", {31'd0, rda}, 32'h1);
      chk("ov2_ov", {31'd0, overrun}, 32'h1);
      idle(7);
      ack_pulse();
      chk("ov_ack_rda", {31'd0, rda}, 32'h0);
      chk("ov_ack_ov", {31'd0, overrun}, 32'h0);

      // Ack coinciding with frame completion
      idle(4);
      send_frame(8'h44, 1'b1, 1'b0);
      chk("ack_pre_rda", {31'd0, rda}, 32'h1);
      idle(7);
      send_frame(8'h55, 1'b1, 1'b1);
      chk("ack_same_data", {24'd0, rx_data}, 32'h55);
      chk("ack_same_rda", {31'd0, rda}, 32'h1);
      chk("ack_same_ov", {31'd0, overrun}, 32'h0);
      idle(7);

      // Reset during data bit 3, then frame 0xF0
      send_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) send_bit(1'(8'h99 >> i), 16);
      send_bit(1'b1, 5);
      rst = 1'b1;
      #1;
      chk("mrst_data", {24'd0, rx_data}, 32'h0);
      chk("mrst_rda", {31'd0, rda}, 32'h0);
      chk("mrst_busy", {31'd0, busy}, 32'h0);
      chk("mrst_ov_fe", {30'd0, overrun, frame_err}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(16);
      chk("mrst_idle_rda", {31'd0, rda}, 32'h0);
      send_frame(8'hF0, 1'b1, 1'b0);
      chk("f0_data", {24'd0, rx_data}, 32'hF0);
      chk("f0_rda", {31'd0, rda}, 32'h1);
      chk("f0_fe", {31'd0, frame_err}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
